// File: rtl/ann_layer_scheduler.sv
// Shares one MAC across all neurons of a dense layer; INPUTS+2 cycles per neuron, all outputs registered.
// Backpressure: while out_valid && !out_ready the result and all memory addresses hold, no new reads.
module ann_layer_scheduler #(
    parameter int INPUTS  = 784,
    parameter int NEURONS = 10,
    parameter int ADDR_W  = 10,
    parameter int NEUR_W  = 4,
    parameter int WADDR_W = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  img_addr,
    input  logic [7:0]         img_data,
    output logic [WADDR_W-1:0] w_addr,
    input  logic [7:0]         w_data,
    output logic [NEUR_W-1:0]  b_addr,
    input  logic [15:0]        b_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NEUR_W-1:0]  out_neuron,
    output logic [15:0]        out_x
);
    typedef enum logic [1:0] {IDLE, BIAS, MAC, OUT} state_t;

    localparam logic [ADDR_W:0]  K_END    = (ADDR_W+1)'(INPUTS);
    localparam logic [ADDR_W:0]  CNT_LAST = (ADDR_W+1)'(INPUTS-1);
    localparam logic [ADDR_W:0]  K_ONE    = (ADDR_W+1)'(1);
    localparam logic [NEUR_W-1:0] N_LAST  = NEUR_W'(NEURONS-1);
    localparam logic [NEUR_W-1:0] N_ONE   = NEUR_W'(1);
    localparam logic [WADDR_W-1:0] W_ONE  = WADDR_W'(1);

    state_t              state_q, state_d;
    logic [NEUR_W-1:0]   n_q, n_d;
    logic [ADDR_W:0]     k_q, k_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic signed [31:0]  acc_q, acc_d;
    logic [ADDR_W-1:0]   img_addr_q, img_addr_d;
    logic [WADDR_W-1:0]  w_addr_q, w_addr_d;
    logic [NEUR_W-1:0]   b_addr_q, b_addr_d;
    logic                out_valid_q, out_valid_d;
    logic [NEUR_W-1:0]   out_neuron_q, out_neuron_d;
    logic [15:0]         out_x_q, out_x_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                go, accept;
    logic signed [16:0]  pix_s, w_s, prod;
    logic signed [31:0]  acc_base, acc_sum, shifted;
    logic [15:0]         sat_x;

    // A start landing in the done cycle is deliberately dropped.
    assign go     = (state_q == IDLE) && start && !done_q;
    assign accept = out_valid_q && out_ready;

    assign pix_s    = {9'b0, img_data};
    assign w_s      = {{9{w_data[7]}}, w_data};
    assign prod     = pix_s * w_s;
    assign acc_base = (cnt_q == '0) ? {{16{b_data[15]}}, b_data} : acc_q;
    assign acc_sum  = acc_base + {{15{prod[16]}}, prod};
    assign shifted  = acc_sum >>> 8;

    always_comb begin
        sat_x = shifted[15:0];
        if (shifted > 32'sd32767)
            sat_x = 16'h7FFF;
        else if (shifted < -32'sd32768)
            sat_x = 16'h8000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            n_q          <= '0;
            k_q          <= '0;
            cnt_q        <= '0;
            acc_q        <= '0;
            img_addr_q   <= '0;
            w_addr_q     <= '0;
            b_addr_q     <= '0;
            out_valid_q  <= 1'b0;
            out_neuron_q <= '0;
            out_x_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            k_q          <= k_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            img_addr_q   <= img_addr_d;
            w_addr_q     <= w_addr_d;
            b_addr_q     <= b_addr_d;
            out_valid_q  <= out_valid_d;
            out_neuron_q <= out_neuron_d;
            out_x_q      <= out_x_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (go) state_d = BIAS;
            BIAS:    state_d = MAC;
            MAC:     if (cnt_q == CNT_LAST) state_d = OUT;
            OUT:     if (accept) state_d = (n_q == N_LAST) ? IDLE : BIAS;
            default: state_d = IDLE;
        endcase
    end

    // Addresses are registered one cycle ahead so the 1-cycle memories line up with the MAC.
    always_comb begin
        n_d          = n_q;
        k_d          = k_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        img_addr_d   = img_addr_q;
        w_addr_d     = w_addr_q;
        b_addr_d     = b_addr_q;
        out_valid_d  = out_valid_q;
        out_neuron_d = out_neuron_q;
        out_x_d      = out_x_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (go) begin
                    n_d        = '0;
                    k_d        = K_ONE;
                    img_addr_d = '0;
                    w_addr_d   = '0;
                    b_addr_d   = '0;
                    busy_d     = 1'b1;
                end
            end
            BIAS: begin
                img_addr_d = k_q[ADDR_W-1:0];
                w_addr_d   = w_addr_q + W_ONE;
                k_d        = k_q + K_ONE;
                cnt_d      = '0;
            end
            MAC: begin
                acc_d = acc_sum;
                cnt_d = cnt_q + K_ONE;
                if (k_q < K_END) begin
                    img_addr_d = k_q[ADDR_W-1:0];
                    w_addr_d   = w_addr_q + W_ONE;
                    k_d        = k_q + K_ONE;
                end
                if (cnt_q == CNT_LAST) begin
                    out_valid_d  = 1'b1;
                    out_x_d      = sat_x;
                    out_neuron_d = n_q;
                end
            end
            OUT: begin
                if (accept) begin
                    out_valid_d = 1'b0;
                    if (n_q == N_LAST) begin
                        done_d = 1'b1;
                        busy_d = 1'b0;
                    end else begin
                        // Weight rows are contiguous, so the next row starts one past the held address.
                        n_d        = n_q + N_ONE;
                        k_d        = K_ONE;
                        img_addr_d = '0;
                        w_addr_d   = w_addr_q + W_ONE;
                        b_addr_d   = n_q + N_ONE;
                    end
                end
            end
            default: ;
        endcase
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign img_addr   = img_addr_q;
    assign w_addr     = w_addr_q;
    assign b_addr     = b_addr_q;
    assign out_valid  = out_valid_q;
    assign out_neuron = out_neuron_q;
    assign out_x      = out_x_q;
endmodule

// File: tb/tb_ann_layer_scheduler.sv
// Directed bench: small 4x2 layer with a cycle-accurate schedule check, plus a 784x1 layer for saturation.
module tb_ann_layer_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Small layer: INPUTS=4, NEURONS=2
    logic        start_a = 1'b0, out_ready_a = 1'b1;
    logic        busy_a, done_a, out_valid_a;
    logic [9:0]  img_addr_a;
    logic [13:0] w_addr_a;
    logic [3:0]  b_addr_a, out_neuron_a;
    logic [15:0] out_x_a;
    logic [7:0]  img_data_a, w_data_a;
    logic [15:0] b_data_a;
    logic [7:0]  img_a [4];
    logic [7:0]  w_a   [8];
    logic [15:0] b_a   [2];

    always @(posedge clk) begin
        img_data_a <= img_a[img_addr_a[1:0]];
        w_data_a   <= w_a[w_addr_a[2:0]];
        b_data_a   <= b_a[b_addr_a[0]];
    end

    ann_layer_scheduler #(.INPUTS(4), .NEURONS(2), .ADDR_W(10), .NEUR_W(4), .WADDR_W(14)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .img_addr(img_addr_a), .img_data(img_data_a), .w_addr(w_addr_a), .w_data(w_data_a),
        .b_addr(b_addr_a), .b_data(b_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_neuron(out_neuron_a), .out_x(out_x_a)
    );

    // Full-width layer: INPUTS=784, NEURONS=1, constant memories
    logic        start_b = 1'b0, out_ready_b = 1'b1;
    logic        busy_b, done_b, out_valid_b;
    logic [9:0]  img_addr_b;
    logic [13:0] w_addr_b;
    logic [3:0]  b_addr_b, out_neuron_b;
    logic [15:0] out_x_b;
    logic [7:0]  img_data_b, w_data_b;
    logic [15:0] b_data_b;
    logic [7:0]  imgv_b = 8'd0, wv_b = 8'd0;
    logic [15:0] bv_b = 16'd0;

    always @(posedge clk) begin
        img_data_b <= imgv_b;
        w_data_b   <= wv_b;
        b_data_b   <= bv_b;
    end

    ann_layer_scheduler #(.INPUTS(784), .NEURONS(1), .ADDR_W(10), .NEUR_W(4), .WADDR_W(14)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .img_addr(img_addr_b), .img_data(img_data_b), .w_addr(w_addr_b), .w_data(w_data_b),
        .b_addr(b_addr_b), .b_data(b_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_neuron(out_neuron_b), .out_x(out_x_b)
    );

    task automatic chk_a_zero(input string tag);
        chk({tag, "_busy"}, busy_a, 0);
        chk({tag, "_done"}, done_a, 0);
        chk({tag, "_vld"}, out_valid_a, 0);
        chk({tag, "_x"}, out_x_a, 0);
        chk({tag, "_nrn"}, out_neuron_a, 0);
        chk({tag, "_img"}, img_addr_a, 0);
        chk({tag, "_w"}, w_addr_a, 0);
        chk({tag, "_b"}, b_addr_a, 0);
    endtask

    // Neuron schedule: phase 0 BIAS, 1..4 MAC, 5 OUT; OUT of neuron 0 stretched by 'stall'.
    task automatic run_a(input int stall, input bit poke, input int rst_at, input int ex0, input int ex1);
        int last, cc, nrn, ph, idx;
        int exp_x [2];
        exp_x[0] = ex0;
        exp_x[1] = ex1;
        last = 13 + stall;
        @(negedge clk);
        start_a = 1'b1;
        out_ready_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        for (int c = 1; c <= last + 1; c++) begin
            @(negedge clk);
            if (c == rst_at) begin
                rst = 1'b1;
                #1 chk_a_zero("rst_mid");
                @(negedge clk);
                rst = 1'b0;
                for (int j = 0; j < 16; j++) begin
                    @(negedge clk);
                    chk("rst_no_done", done_a, 0);
                end
                chk("rst_idle_busy", busy_a, 0);
                return;
            end
            if (c >= 6 && c <= 6 + stall) cc = 6;
            else if (c > 6 + stall)       cc = c - stall;
            else                          cc = c;
            if (cc <= 12) begin
                nrn = (cc - 1) / 6;
                ph  = (cc - 1) % 6;
                idx = (ph < 3) ? ph : 3;
                chk("busy", busy_a, 1);
                chk("done_early", done_a, 0);
                chk("w_addr", w_addr_a, nrn * 4 + idx);
                chk("img_addr", img_addr_a, idx);
                chk("b_addr", b_addr_a, nrn);
                chk("out_valid", out_valid_a, (ph == 5) ? 1 : 0);
                if (ph == 5) begin
                    chk("out_x", $signed(out_x_a), exp_x[nrn]);
                    chk("out_neuron", out_neuron_a, nrn);
                end
            end else if (cc == 13) begin
                chk("done", done_a, 1);
                chk("done_busy", busy_a, 0);
                chk("done_vld", out_valid_a, 0);
                start_a = 1'b1;
            end else begin
                chk("done_pulse", done_a, 0);
                chk("start_in_done_ignored", busy_a, 0);
                start_a = 1'b0;
            end
            out_ready_a = !(c >= 6 && c < 6 + stall);
            if (poke && c == 3) start_a = 1'b1;
            if (poke && c == 4) start_a = 1'b0;
        end
    endtask

    task automatic run_b(input logic [7:0] iv, input logic [7:0] wv, input logic [15:0] bv,
                         input int ex, input string tg);
        int seen;
        seen = 0;
        imgv_b = iv;
        wv_b   = wv;
        bv_b   = bv;
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        #1 start_b = 1'b0;
        for (int c = 1; c <= 2000 && seen == 0; c++) begin
            @(negedge clk);
            if (out_valid_b) seen = c;
        end
        chk({tg, "_lat"}, seen, 786);
        if (seen != 0) begin
            chk(tg, $signed(out_x_b), ex);
            chk({tg, "_nrn"}, out_neuron_b, 0);
            @(negedge clk);
            chk({tg, "_done"}, done_b, 1);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) img_a[i] = 8'd255;
        for (int i = 0; i < 8; i++) w_a[i] = 8'd127;
        b_a[0] = 16'd0;
        b_a[1] = 16'd0;

        #12 chk_a_zero("reset");
        chk("reset_b_vld", out_valid_b, 0);
        @(negedge clk);
        rst = 1'b0;

        run_a(0, 1'b0, 0, 506, 506);

        run_b(8'd255, 8'd127, 16'd0, 32767, "sat_pos");
        run_b(8'd255, 8'h80, 16'd0, -32768, "sat_neg");
        run_b(8'd255, 8'd0, 16'hFF00, -1, "bias_only");

        img_a[0] = 8'd200; img_a[1] = 8'd3; img_a[2] = 8'd255; img_a[3] = 8'd1;
        w_a[0] = 8'd100;   w_a[1] = 8'hCE;  w_a[2] = 8'd2;     w_a[3] = 8'd7;
        w_a[4] = 8'h80;    w_a[5] = 8'd127; w_a[6] = 8'hFF;    w_a[7] = 8'd0;
        b_a[0] = 16'd1000;
        b_a[1] = 16'hFED4;
        run_a(5, 1'b1, 0, 83, -101);
        run_a(0, 1'b0, 9, 83, -101);

        b_a[0] = 16'hFC18;
        b_a[1] = 16'd300;
        run_a(0, 1'b0, 0, 75, -99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ann_layer_scheduler.md
# ann_layer_scheduler

Sequences one shared multiply-accumulate datapath across every neuron of a fully connected layer. For each neuron it streams the input image and that neuron's weight row from synchronous-read memories, adds the bias, and scales and saturates the sum to a 16-bit signed pre-activation. It presents the result through a valid/ready output port that feeds the sigmoid lookup. It sits between the image/weight/bias memories and the activation stage, replacing per-neuron combinational accumulation loops.

## Interface
- INPUTS, 784, inputs per neuron (≥2)
- NEURONS, 10, neurons in the layer (≥1)
- ADDR_W, 10, image address width (2^ADDR_W ≥ INPUTS)
- NEUR_W, 4, neuron index width (2^NEUR_W ≥ NEURONS)
- WADDR_W, 14, weight address width (2^WADDR_W ≥ INPUTS·NEURONS)
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a layer pass; sampled only in IDLE
- busy  out  1  high in BIAS/MAC/OUT
- done  out  1  one-cycle pulse when the pass completes
- img_addr  out  ADDR_W  image memory read address
- img_data  in  8  unsigned pixel, valid 1 cycle after address
- w_addr  out  WADDR_W  weight address = neuron·INPUTS + index
- w_data  in  8  signed weight, valid 1 cycle after address
- b_addr  out  NEUR_W  bias memory address
- b_data  in  16  signed bias, valid 1 cycle after address
- out_valid  out  1  pre-activation available
- out_ready  in  1  consumer accepts
- out_neuron  out  NEUR_W  neuron index of out_x
- out_x  out  16  signed saturated pre-activation

## Operation
- States: IDLE, BIAS, MAC, OUT.
- **IDLE**
  - start=1 → BIAS with neuron n=0.
  - start is ignored in every other state.
- **BIAS** (1 cycle)
  - Drives b_addr=n, img_addr=0, w_addr=n·INPUTS.
  - Index k←1.
  - → MAC.
- **MAC** (exactly INPUTS cycles)
  - First cycle: acc ← sext(b_data) + img_data·w_data.
  - Later cycles: acc ← acc + img_data·w_data.
  - While k<INPUTS: drives img_addr=k, w_addr=n·INPUTS+k, then k←k+1.
  - Addresses hold once k reaches INPUTS.
  - After the INPUTS-th accumulate → OUT.
- **OUT**
  - out_valid=1, out_x=sat16(acc>>>8), out_neuron=n.
  - On out_valid&&out_ready: if n<NEURONS-1, n←n+1 and → BIAS.
  - Otherwise → IDLE and done=1 for that one cycle.
- **Arithmetic**
  - Product: {1'b0,img_data} × w_data, 17-bit signed.
  - acc: 32-bit signed.
  - Shift is arithmetic by 8.
  - Saturation clamps to [−32768, 32767]; the result is never truncated.
- **Backpressure**
  - While out_valid&&!out_ready, out_x, out_neuron and all addresses are held stable.
  - No memory reads are issued during backpressure.
- **Reset** (asynchronous, any state, including mid-MAC)
  - State=IDLE, n=0, k=0, acc=0.
  - busy=0, done=0, out_valid=0, out_x=0, out_neuron=0, img_addr=0, w_addr=0, b_addr=0.
  - A reset during a pass produces no done and no partial output.
  - A later start begins a fresh pass from neuron 0.

## Timing
- All outputs are registered.
- Memory read latency is exactly 1 cycle.
- Start sampled at edge t: BIAS in cycle t+1, MAC in t+2…t+1+INPUTS, OUT from t+2+INPUTS.
- With out_ready held high:
  - Each neuron takes INPUTS+2 cycles.
  - done is asserted in cycle t+1+NEURONS·(INPUTS+2).
  - busy=0 in the done cycle.
- A start asserted in the done cycle is ignored. The first accepted start is on the following edge.

## Test plan
- **Positive result:** INPUTS=4, NEURONS=2, all img=255, all w=127, biases 0 → out_x=506 (129540>>>8) for neurons 0 and 1; out_neuron 0 then 1; single done at cycle t+13.
- **Saturation:** INPUTS=784, NEURONS=1.
  - img=255, w=127, bias 0 → out_x=32767.
  - img=255, w=−128 → out_x=−32768.
  - bias=−256 with all w=0 → out_x=−1.
- **Address sequencing:** INPUTS=4, NEURONS=2 → w_addr 0,1,2,3 then 4,5,6,7; img_addr 0..3 twice; b_addr 0 then 1.
- **Backpressure:** out_ready low 5 cycles in OUT of neuron 0 → out_valid stays 1, out_x unchanged, no BIAS for neuron 1 until ready; done delayed by exactly 5 cycles.
- **Start while busy:** start pulsed mid-MAC → ignored; exactly NEURONS outputs and one done.
- **Reset mid-pass:** rst in MAC cycle 2 of neuron 1 → all outputs 0 asynchronously, no done. Restart then gives correct fresh results starting at neuron 0 with bias re-read.
